// File: rtl/vga_timing_core.sv
// Raster timing generator: h/v counters, registered sync/blank, line/frame strobes.
// Optional frame counter built only when VGA_TIMING_FRAME_COUNT_EN is defined.
module vga_timing_core #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic        vga_clk,
   input  logic        reset,
   input  logic        pix_en,
   output logic        blank_n,
   output logic        HS,
   output logic        VS,
   output logic [10:0] xPos,
   output logic [9:0]  yPos,
   output logic        line_tick,
   output logic        frame_tick,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

   localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
   localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);

   if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_param_check
      $error("vga_timing_core: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
   end

   logic [10:0] x_nxt;
   logic [9:0]  y_nxt;
   logic        blank_nxt;
   logic        hs_nxt;
   logic        vs_nxt;
   logic        land_line;
   logic        land_frame;

   // Decode the position being loaded so sync/blank register alongside it, skew-free.
   always_comb begin
      x_nxt = xPos + 11'd1;
      y_nxt = yPos;
      if (xPos == X_LAST) begin
         x_nxt = '0;
         y_nxt = (yPos == Y_LAST) ? '0 : yPos + 10'd1;
      end
      blank_nxt  = (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
      hs_nxt     = ((int'(x_nxt) >= HS_START) && (int'(x_nxt) < HS_END)) ? HS_POL : ~HS_POL;
      vs_nxt     = ((int'(y_nxt) >= VS_START) && (int'(y_nxt) < VS_END)) ? VS_POL : ~VS_POL;
      land_line  = (x_nxt == '0);
      land_frame = (x_nxt == '0) && (y_nxt == '0);
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         xPos       <= X_LAST;
         yPos       <= Y_LAST;
         blank_n    <= 1'b0;
         HS         <= ~HS_POL;
         VS         <= ~VS_POL;
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end else if (pix_en) begin
         xPos       <= x_nxt;
         yPos       <= y_nxt;
         blank_n    <= blank_nxt;
         HS         <= hs_nxt;
         VS         <= vs_nxt;
         line_tick  <= land_line;
         frame_tick <= land_frame;
      end else begin
         line_tick  <= 1'b0;
         frame_tick <= 1'b0;
      end
   end

`ifdef VGA_TIMING_FRAME_COUNT_EN
   logic [15:0] frame_cnt_q;

   // Counts on the same edge that raises frame_tick, so frame N reads N throughout.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         frame_cnt_q <= '0;
      end else if (pix_en && land_frame) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_count = frame_cnt_q;
`else
   assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: default-size and small-raster instances against a position-index model.
module tb_vga_timing_core;

   // Small raster so whole frames fit in a short run; non-default polarities.
   localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
   localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 2;
   localparam longint D_T = 800 * 525;
   localparam longint S_T = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

   logic        vga_clk;
   logic        d_rst, d_en, s_rst, s_en;
   logic        d_blank, d_hs, d_vs, d_lt, d_ft;
   logic        s_blank, s_hs, s_vs, s_lt, s_ft;
   logic [10:0] d_x, s_x;
   logic [9:0]  d_y, s_y;
   logic [15:0] d_fc, s_fc;

   int tests = 0;
   int fails = 0;

   longint dk = 0, sk = 0;
   bit     d_adv = 0, s_adv = 0;
   longint s_off = 0;

   vga_timing_core dut_d (
      .vga_clk(vga_clk), .reset(d_rst), .pix_en(d_en),
      .blank_n(d_blank), .HS(d_hs), .VS(d_vs), .xPos(d_x), .yPos(d_y),
      .line_tick(d_lt), .frame_tick(d_ft), .frame_count(d_fc)
   );

   vga_timing_core #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut_s (
      .vga_clk(vga_clk), .reset(s_rst), .pix_en(s_en),
      .blank_n(s_blank), .HS(s_hs), .VS(s_vs), .xPos(s_x), .yPos(s_y),
      .line_tick(s_lt), .frame_tick(s_ft), .frame_count(s_fc)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   typedef struct {
      int x; int y; int blank; int hs; int vs; int lt; int ft;
   } exp_t;

   // k = enabled advances since reset; position index (k-1) mod (H_TOTAL*V_TOTAL).
   function automatic exp_t ref_out(int ha, int hf, int hsw, int hb,
                                    int va, int vf, int vsw, int vb,
                                    bit hp, bit vp, longint k, bit adv);
      exp_t   e;
      longint ht = longint'(ha + hf + hsw + hb);
      longint t  = ht * longint'(va + vf + vsw + vb);
      longint p  = (k + t - 1) % t;
      e.x     = int'(p % ht);
      e.y     = int'(p / ht);
      e.blank = (e.x < ha && e.y < va) ? 1 : 0;
      e.hs    = (e.x >= ha + hf && e.x < ha + hf + hsw) ? int'(hp) : int'(!hp);
      e.vs    = (e.y >= va + vf && e.y < va + vf + vsw) ? int'(vp) : int'(!vp);
      e.lt    = (adv && e.x == 0) ? 1 : 0;
      e.ft    = (adv && p == 0) ? 1 : 0;
      return e;
   endfunction

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic int exp_fc(longint k, longint t, longint off);
`ifdef VGA_TIMING_FRAME_COUNT_EN
      return int'(((k + t - 1) / t + off) % 65536);
`else
      return 0;
`endif
   endfunction

   task automatic check_all();
      exp_t e;
      e = ref_out(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, dk, d_adv);
      cmp("d.xPos", 32'(d_x), e.x);
      cmp("d.yPos", 32'(d_y), e.y);
      cmp("d.blank_n", 32'(d_blank), e.blank);
      cmp("d.HS", 32'(d_hs), e.hs);
      cmp("d.VS", 32'(d_vs), e.vs);
      cmp("d.line_tick", 32'(d_lt), e.lt);
      cmp("d.frame_tick", 32'(d_ft), e.ft);
      cmp("d.frame_count", 32'(d_fc), exp_fc(dk, D_T, 0));
      e = ref_out(SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b1, 1'b1, sk, s_adv);
      cmp("s.xPos", 32'(s_x), e.x);
      cmp("s.yPos", 32'(s_y), e.y);
      cmp("s.blank_n", 32'(s_blank), e.blank);
      cmp("s.HS", 32'(s_hs), e.hs);
      cmp("s.VS", 32'(s_vs), e.vs);
      cmp("s.line_tick", 32'(s_lt), e.lt);
      cmp("s.frame_tick", 32'(s_ft), e.ft);
      cmp("s.frame_count", 32'(s_fc), exp_fc(sk, S_T, s_off));
   endtask

   // One clock edge: update models from the inputs applied across it, then check.
   task automatic step();
      @(posedge vga_clk);
      #1;
      if (d_rst) begin dk = 0; d_adv = 0; end
      else if (d_en) begin dk++; d_adv = 1; end
      else d_adv = 0;
      if (s_rst) begin sk = 0; s_adv = 0; s_off = 0; end
      else if (s_en) begin sk++; s_adv = 1; end
      else s_adv = 0;
      check_all();
   endtask

   typedef struct {
      bit rst; bit en; int n;
      int x; int y; int blank; int hs; int vs; int lt; int ft;
   } vec_t;

   vec_t vecs[16];

   initial begin
      int cnt_blank, cnt_hs, cnt_lt, cnt_ft, cnt_vs;
      int t_first, t_last;

      //                 rst en   n    x    y  bl hs vs lt ft
      vecs[0]  = '{1, 1,   5, 799, 524, 0, 1, 1, 0, 0};
      vecs[1]  = '{0, 1,   1,   0,   0, 1, 1, 1, 1, 1};
      vecs[2]  = '{0, 0,   3,   0,   0, 1, 1, 1, 0, 0};
      vecs[3]  = '{0, 1,   1,   1,   0, 1, 1, 1, 0, 0};
      vecs[4]  = '{0, 1, 638, 639,   0, 1, 1, 1, 0, 0};
      vecs[5]  = '{0, 1,   1, 640,   0, 0, 1, 1, 0, 0};
      vecs[6]  = '{0, 1,  15, 655,   0, 0, 1, 1, 0, 0};
      vecs[7]  = '{0, 1,   1, 656,   0, 0, 0, 1, 0, 0};
      vecs[8]  = '{0, 1,  95, 751,   0, 0, 0, 1, 0, 0};
      vecs[9]  = '{0, 1,   1, 752,   0, 0, 1, 1, 0, 0};
      vecs[10] = '{0, 1,  47, 799,   0, 0, 1, 1, 0, 0};
      vecs[11] = '{0, 1,   1,   0,   1, 1, 1, 1, 1, 0};
      vecs[12] = '{0, 1, 300, 300,   1, 1, 1, 1, 0, 0};
      vecs[13] = '{1, 1,   1, 799, 524, 0, 1, 1, 0, 0};
      vecs[14] = '{0, 0,   2, 799, 524, 0, 1, 1, 0, 0};
      vecs[15] = '{0, 1,   1,   0,   0, 1, 1, 1, 1, 1};

      d_rst = 1'b1; d_en = 1'b1; s_rst = 1'b1; s_en = 1'b1;

      for (int i = 0; i < 16; i++) begin
         d_rst = vecs[i].rst;
         d_en  = vecs[i].en;
         repeat (vecs[i].n) step();
         cmp($sformatf("vec%0d.xPos", i), 32'(d_x), vecs[i].x);
         cmp($sformatf("vec%0d.yPos", i), 32'(d_y), vecs[i].y);
         cmp($sformatf("vec%0d.blank_n", i), 32'(d_blank), vecs[i].blank);
         cmp($sformatf("vec%0d.HS", i), 32'(d_hs), vecs[i].hs);
         cmp($sformatf("vec%0d.VS", i), 32'(d_vs), vecs[i].vs);
         cmp($sformatf("vec%0d.line_tick", i), 32'(d_lt), vecs[i].lt);
         cmp($sformatf("vec%0d.frame_tick", i), 32'(d_ft), vecs[i].ft);
      end

      // One full-rate line starting just after (0,0).
      d_rst = 1'b0; d_en = 1'b1;
      cnt_blank = 0; cnt_hs = 0; cnt_lt = 0;
      for (int i = 0; i < 800; i++) begin
         step();
         cnt_blank += int'(d_blank);
         cnt_hs    += int'(!d_hs);
         cnt_lt    += int'(d_lt);
      end
      cmp("line.blank_cycles", 32'(cnt_blank), 640);
      cmp("line.hs_cycles", 32'(cnt_hs), 96);
      cmp("line.line_ticks", 32'(cnt_lt), 1);

      // Half-rate enable: line period doubles.
      cnt_lt = 0; t_first = -1; t_last = -1;
      for (int i = 0; i < 3200; i++) begin
         d_en = (i % 2 == 0);
         step();
         if (d_lt) begin
            cnt_lt++;
            if (t_first < 0) t_first = i;
            t_last = i;
         end
      end
      cmp("half.line_ticks", 32'(cnt_lt), 2);
      cmp("half.line_period", 32'(t_last - t_first), 1600);
      d_en = 1'b1;

      // Small raster: reset state and first advance.
      cmp("s.reset.xPos", 32'(s_x), 14);
      cmp("s.reset.yPos", 32'(s_y), 10);
      cmp("s.reset.HS", 32'(s_hs), 0);
      cmp("s.reset.VS", 32'(s_vs), 0);
      s_rst = 1'b0;
      step();
      cmp("s.first.xy", {s_x, 11'd0, s_y}, {11'd0, 11'd0, 10'd0});
      cmp("s.first.ticks", {30'd0, s_lt, s_ft}, 32'd3);

      // Two full frames at full rate.
      cnt_blank = 0; cnt_vs = 0; cnt_ft = 0; t_first = -1; t_last = -1;
      for (int i = 1; i <= 2 * int'(S_T); i++) begin
         step();
         cnt_blank += int'(s_blank);
         cnt_vs    += int'(s_vs);
         if (s_ft) begin
            cnt_ft++;
            if (t_first < 0) t_first = i;
            t_last = i;
         end
      end
      cmp("frame.frame_ticks", 32'(cnt_ft), 2);
      cmp("frame.period", 32'(t_last - t_first), 32'(S_T));
      cmp("frame.blank_cycles", 32'(cnt_blank), 2 * SHA * SVA);
      cmp("frame.vs_cycles", 32'(cnt_vs), 2 * SVS * (SHA + SHF + SHS + SHB));
`ifdef VGA_TIMING_FRAME_COUNT_EN
      cmp("fc.three_frames", 32'(s_fc), 3);
      force dut_s.frame_cnt_q = 16'hFFFF;
      #1;
      release dut_s.frame_cnt_q;
      s_off = 65535 - (sk + S_T - 1) / S_T;
      while (!s_ft) step();
      cmp("fc.wrap", 32'(s_fc), 0);
`else
      cmp("fc.disabled", 32'(s_fc), 0);
`endif

      // Random enable with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         s_en  = ($urandom_range(0, 2) != 0);
         s_rst = ($urandom_range(0, 299) == 0);
         d_en  = $urandom_range(0, 1) == 1;
         step();
      end

      // Mid-frame reset lands straight back on the reset values.
      s_rst = 1'b1; s_en = 1'b1;
      step();
      s_rst = 1'b0;
      repeat (63) step();
      cmp("mid.pre.xPos", 32'(s_x), 2);
      cmp("mid.pre.yPos", 32'(s_y), 4);
      s_rst = 1'b1; s_en = 1'b0;
      step();
      cmp("mid.rst.xPos", 32'(s_x), 14);
      cmp("mid.rst.yPos", 32'(s_y), 10);
      cmp("mid.rst.ticks", {30'd0, s_lt, s_ft}, 0);
      s_rst = 1'b0; s_en = 1'b1;
      step();
      cmp("mid.rec.xy", {s_x, 11'd0, s_y}, 0);
      cmp("mid.rec.blank_n", 32'(s_blank), 1);
      cmp("mid.rec.ticks", {30'd0, s_lt, s_ft}, 32'd3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
